// File: rtl/ttl_ring_fifo_if.sv
// rtl/ttl_ring_fifo_if.sv - write/read/status bundle between the TTL path writer and the ring FIFO
interface ttl_ring_fifo_if #(
    parameter int ADDR_LEN = 10,
    parameter int DATA_LEN = 8
);
    logic                wr_en;
    logic [DATA_LEN-1:0] din;
    logic                rd_en;
    logic                clear_err;
    logic [DATA_LEN-1:0] dout;
    logic                dout_valid;
    logic                full;
    logic                empty;
    logic                almost_full;
    logic [ADDR_LEN:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output wr_en, din, rd_en, clear_err,
        input  dout, dout_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clear_err,
        output dout, dout_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/ttl_ring_fifo.sv
// rtl/ttl_ring_fifo.sv - circular FIFO with occupancy flags, sticky errors and FWFT/registered read modes
module ttl_ring_fifo #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_LEN  = 10,
    parameter int DATA_LEN  = 8,
    parameter int THRESHOLD = 1000,
    parameter int FWFT      = 1
) (
    input  logic          clk,
    input  logic          rst,
    ttl_ring_fifo_if.slave bus
);
    localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN + 1)'(DEPTH);
    localparam logic [ADDR_LEN:0] THR_C   = (ADDR_LEN + 1)'(THRESHOLD);

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [ADDR_LEN-1:0] wp;
    logic [ADDR_LEN-1:0] rp;
    logic [ADDR_LEN:0]   cnt;
    logic                ovf;
    logic                unf;
    logic                is_full;
    logic                is_empty;
    logic                wa;
    logic                ra;

    assign is_full  = (cnt == DEPTH_C);
    assign is_empty = (cnt == '0);
    // Gating on the registered flags alone rejects write-through on empty and read-frees-slot on full
    assign wa = bus.wr_en & ~is_full;
    assign ra = bus.rd_en & ~is_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wa) wp <= wp + 1'b1;
            if (ra) rp <= rp + 1'b1;
            case ({wa, ra})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A fresh error in the clearing cycle keeps the flag set
            ovf <= (ovf & ~bus.clear_err) | (bus.wr_en & is_full);
            unf <= (unf & ~bus.clear_err) | (bus.rd_en & is_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wa) mem[wp] <= bus.din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout       = is_empty ? '0 : mem[rp];
            assign bus.dout_valid = ~is_empty;
        end else begin : g_reg
            logic [DATA_LEN-1:0] dout_q;
            logic                valid_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= ra;
                    if (ra) dout_q <= mem[rp];
                end
            end
            assign bus.dout       = dout_q;
            assign bus.dout_valid = valid_q;
        end
    endgenerate

    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almost_full = (cnt >= THR_C);
    assign bus.count       = cnt;
    assign bus.overflow    = ovf;
    assign bus.underflow   = unf;
endmodule
